// File: rtl/edge_pack_pkg.sv
// Shared types and constants for the edge-stream packing stage.
package edge_pack_pkg;

    localparam int unsigned EDGE_CNT_W = 19;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } pack_word_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
module sync_fifo #(
    parameter type         data_t = logic [7:0],
    parameter int unsigned Depth  = 16
) (
    input  logic  clk,
    input  logic  rstN,
    input  logic  wr_en,
    input  data_t wr_data,
    input  logic  rd_en,
    output data_t rd_data,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AddrW = $clog2(Depth);

    data_t            mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        do_rd = rd_en && !empty;
        // A read frees the slot in the same cycle, so a full FIFO still accepts.
        do_wr = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + (AddrW+1)'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + (AddrW+1)'(1);
        end
        rd_data = mem_q[rd_ptr_q[AddrW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/edge_stream_packer.sv
// Packs 1-bit edge decisions MSB-first into tagged bytes behind a FWFT FIFO,
// with per-frame edge counting and a sticky drop flag.
module edge_stream_packer
    import edge_pack_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 504,
    parameter int unsigned IMG_HEIGHT = 504,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [7:0]            edge_in,
    input  logic                  edge_in_valid,
    output logic [7:0]            pack_data,
    output logic                  pack_sof,
    output logic                  pack_eol,
    output logic                  pack_eof,
    output logic                  pack_valid,
    input  logic                  pack_ready,
    output logic                  frame_done,
    output logic [EDGE_CNT_W-1:0] frame_edge_count,
    output logic                  overflow
);

    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            shift_q, shift_d;
    logic                  sof_pend_q, sof_pend_d;
    logic [EDGE_CNT_W-1:0] run_q, run_d;
    logic [EDGE_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;

    logic                  pix_bit, last_col, last_row, emit;
    logic [7:0]            shifted;
    pack_word_t            wr_word, head_word;
    logic                  fifo_full, fifo_empty, rd_en;

    always_comb begin
        pix_bit  = |edge_in;
        last_col = (col_q == ColW'(IMG_WIDTH - 1));
        last_row = (row_q == RowW'(IMG_HEIGHT - 1));
        emit     = edge_in_valid && ((bit_cnt_q == 3'd7) || last_col);
        shifted  = {shift_q, pix_bit};

        // Left-justify so a short end-of-row byte is zero-padded in the LSBs.
        wr_word.data = shifted << (3'd7 - bit_cnt_q);
        wr_word.sof  = sof_pend_q;
        wr_word.eol  = last_col;
        wr_word.eof  = last_col && last_row;

        col_d        = col_q;
        row_d        = row_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sof_pend_d   = sof_pend_q;
        run_d        = run_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        if (edge_in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end

            if (emit) begin
                bit_cnt_d  = '0;
                shift_d    = '0;
                sof_pend_d = last_col && last_row;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = shifted[6:0];
            end

            if (last_col && last_row) begin
                frame_cnt_d  = run_q + EDGE_CNT_W'(pix_bit);
                run_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                run_d = run_q + EDGE_CNT_W'(pix_bit);
            end
        end

        if (emit && fifo_full && !rd_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            col_q        <= '0;
            row_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sof_pend_q   <= 1'b1;
            run_q        <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sof_pend_q   <= sof_pend_d;
            run_q        <= run_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .data_t (pack_word_t),
        .Depth  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstN    (rstN),
        .wr_en   (emit),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Outputs are masked while empty so stale storage never shows through.
    always_comb begin
        pack_valid = !fifo_empty;
        rd_en      = pack_valid && pack_ready;
        pack_data  = pack_valid ? head_word.data : 8'h00;
        pack_sof   = pack_valid && head_word.sof;
        pack_eol   = pack_valid && head_word.eol;
        pack_eof   = pack_valid && head_word.eof;
    end

    assign frame_done       = frame_done_q;
    assign frame_edge_count = frame_cnt_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_edge_stream_packer.sv
// Randomized scoreboard bench: stimulus pushes reference words/frame counts,
// a negedge monitor pops and compares on every accepted word and frame_done.
module tb_edge_stream_packer;
    import edge_pack_pkg::*;

    localparam int unsigned W     = 20;
    localparam int unsigned H     = 3;
    localparam int unsigned DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic [7:0]            edge_in;
    logic                  edge_in_valid;
    logic [7:0]            pack_data;
    logic                  pack_sof, pack_eol, pack_eof, pack_valid;
    logic                  pack_ready;
    logic                  frame_done;
    logic [EDGE_CNT_W-1:0] frame_edge_count;
    logic                  overflow;

    edge_stream_packer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rstN             (rstN),
        .edge_in          (edge_in),
        .edge_in_valid    (edge_in_valid),
        .pack_data        (pack_data),
        .pack_sof         (pack_sof),
        .pack_eol         (pack_eol),
        .pack_eof         (pack_eof),
        .pack_valid       (pack_valid),
        .pack_ready       (pack_ready),
        .frame_done       (frame_done),
        .frame_edge_count (frame_edge_count),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    pack_word_t            exp_q[$];
    logic [EDGE_CNT_W-1:0] frame_q[$];

    // Reference model state: pixel index within frame and bits of the open byte.
    int   pix_idx     = 0;
    int   run_cnt     = 0;
    int   words_issued = 0;
    int   push_limit  = -1;
    bit   chunk[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            if (pack_valid && pack_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL word_unexpected: got %0h expected none",
                             {pack_data, pack_sof, pack_eol, pack_eof});
                end else begin
                    pack_word_t e;
                    e = exp_q.pop_front();
                    check("word", {21'b0, pack_data, pack_sof, pack_eol, pack_eof}, {21'b0, e});
                end
            end
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_done_unexpected: got count %0d expected no pulse",
                             frame_edge_count);
                end else begin
                    logic [EDGE_CNT_W-1:0] c;
                    c = frame_q.pop_front();
                    check("frame_edge_count", 32'(frame_edge_count), 32'(c));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        pix_idx = 0;
        run_cnt = 0;
        chunk.delete();
        exp_q.delete();
        frame_q.delete();
    endtask

    // Drive one valid pixel and update the reference; done=1 if it closes a byte.
    task automatic send(input logic [7:0] v, output bit done);
        int col, row, start;
        pack_word_t w;
        bit b;
        b   = (v != 8'd0);
        col = pix_idx % W;
        row = pix_idx / W;
        chunk.push_back(b);
        run_cnt += int'(b);
        done = (chunk.size() == 8) || (col == W - 1);
        if (done) begin
            start  = col - chunk.size() + 1;
            w.data = 8'h00;
            for (int i = 0; i < chunk.size(); i++) w.data[7-i] = chunk[i];
            w.sof  = (row == 0) && (start == 0);
            w.eol  = (col == W - 1);
            w.eof  = (col == W - 1) && (row == H - 1);
            words_issued++;
            if (push_limit < 0 || words_issued <= push_limit) exp_q.push_back(w);
            chunk.delete();
        end
        if (pix_idx == W * H - 1) begin
            frame_q.push_back(EDGE_CNT_W'(run_cnt));
            run_cnt = 0;
            pix_idx = 0;
        end else begin
            pix_idx++;
        end
        edge_in       = v;
        edge_in_valid = 1'b1;
    endtask

    task automatic idle();
        edge_in       = 8'($urandom);
        edge_in_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_pix();
        return $urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'd0;
    endfunction

    task automatic wait_drain(input int budget);
        idle();
        pack_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && frame_q.size() == 0) break;
            tick();
        end
        tick();
        check("drain_words_left", 32'(exp_q.size()), 32'd0);
        check("drain_frames_left", 32'(frame_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        pack_ready = 1'b0;
        idle();
        rstN = 1'b0;
        model_reset();
        tick();
        tick();
    endtask

    initial begin
        bit done;
        pack_ready = 1'b0;
        do_reset();

        check("rst_pack_valid", 32'(pack_valid), 32'd0);
        check("rst_pack_tags", {29'b0, pack_sof, pack_eol, pack_eof}, 32'd0);
        check("rst_pack_data", 32'(pack_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_edge_count", 32'(frame_edge_count), 32'd0);
        rstN = 1'b1;

        // Alternating 255/0 frame, then an all-ones frame, ready held high.
        pack_ready = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            send((i % 2 == 0) ? 8'd255 : 8'd0, done);
            tick();
        end
        for (int i = 0; i < W * H; i++) begin
            send(8'd1, done);
            tick();
        end

        // Two random frames with valid on alternate cycles and random ready.
        for (int i = 0; i < 4 * W * H; i++) begin
            pack_ready = 1'($urandom_range(0, 1));
            if (i % 2 == 0) send(rand_pix(), done);
            else idle();
            tick();
        end
        wait_drain(500);

        // Fill to full, then read and write on the same edge.
        words_issued = 0;
        pack_ready   = 1'b0;
        do begin
            send(rand_pix(), done);
            if (done && words_issued == DEPTH + 1) pack_ready = 1'b1;
            tick();
        end while (!(done && words_issued == DEPTH + 1));
        while (pix_idx != 0) begin
            send(rand_pix(), done);
            tick();
        end
        wait_drain(500);
        check("full_rw_no_overflow", 32'(overflow), 32'd0);

        // Stall the consumer long enough to force drops.
        words_issued = 0;
        push_limit   = DEPTH;
        pack_ready   = 1'b0;
        for (int i = 0; i < 150; i++) begin
            send(rand_pix(), done);
            tick();
        end
        idle();
        tick();
        check("overflow_set", 32'(overflow), 32'd1);
        check("fifo_full_count", 32'(exp_q.size()), 32'(DEPTH));
        wait_drain(500);
        push_limit = -1;
        while (pix_idx != 0) begin
            send(rand_pix(), done);
            tick();
        end
        wait_drain(500);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reset after 37 pixels with words still buffered.
        pack_ready = 1'b0;
        for (int i = 0; i < 37; i++) begin
            send(rand_pix(), done);
            tick();
        end
        do_reset();
        rstN = 1'b1;
        check("midrst_pack_valid", 32'(pack_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < W * H; i++) begin
            pack_ready = 1'($urandom_range(0, 1));
            send(rand_pix(), done);
            tick();
        end
        wait_drain(500);
        check("final_overflow", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
